// File: rtl/echo_arb_pkg.sv
// -----------------------------------------------------------------------------
// echo_arb_pkg
// Shared types and constants for the echo indication arbiter.
//   DEFAULT_DATA_WIDTH : default echo payload width
//   echo_data_t        : echo payload at the default width
//   MAX_REQ            : largest supported requester count
//   src_idx_t          : requester index wide enough for MAX_REQ requesters
// -----------------------------------------------------------------------------
package echo_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int MAX_REQ            = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] echo_data_t;
    typedef logic [$clog2(MAX_REQ)-1:0]    src_idx_t;

endpackage : echo_arb_pkg

// File: rtl/echo_indication_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotate-priority picker. Scans the request vector from
// index ptr upward, wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : index the scan starts from
//   found : at least one request is set
//   idx   : winning index (0 when found is low)
// -----------------------------------------------------------------------------
module rr_pick
    import echo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/echo_indication_arbiter.sv
// -----------------------------------------------------------------------------
// echo_indication_arbiter
// Shares one downstream EchoIndication.echo method port between NUM_REQ
// responders. Each requester owns a one-entry holding slot; every cycle in
// which the output slot is free, one pending holding slot is moved into the
// output slot in round-robin order.
//
// Handshake (both sides): a method call happens in a cycle where __ENA and
// __RDY are both high. Requester side: req_echo__RDY[i] is a registered
// "holding slot empty" flag; __ENA while __RDY is low is ignored. Downstream:
// ind_echo__ENA is out_valid & ind_echo__RDY and is never raised while the
// downstream is not ready.
//
// Ports:
//   CLK, nRST       : clock, asynchronous active-low reset
//   req_echo__ENA   : per-requester method enable
//   req_echo_v      : per-requester payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_echo__RDY   : per-requester ready (holding slot empty)
//   ind_echo__ENA   : downstream echo call
//   ind_echo_v      : downstream payload
//   ind_echo__RDY   : downstream ready
//   ind_echo_src    : requester index of the value in the output slot
//   stall_count     : saturating count of cycles the output slot waited on a
//                     not-ready downstream; only when ECHO_ARB_STATS_EN is defined
//
// Build option: ECHO_ARB_STATS_EN adds stall_count.
// -----------------------------------------------------------------------------
module echo_indication_arbiter
    import echo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,    // 2..MAX_REQ
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_REQ-1:0]            req_echo__ENA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_echo_v,
    output logic [NUM_REQ-1:0]            req_echo__RDY,
    output logic                          ind_echo__ENA,
    output logic [DATA_WIDTH-1:0]         ind_echo_v,
    input  logic                          ind_echo__RDY,
    output logic [$clog2(NUM_REQ)-1:0]    ind_echo_src
`ifdef ECHO_ARB_STATS_EN
    ,
    output logic [31:0]                   stall_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    hold_valid;
    logic [DATA_WIDTH-1:0] hold_data [NUM_REQ];
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]      out_src;
    logic [IDX_W-1:0]      rr_ptr;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  slot_free;
    logic                  grant;
    logic [NUM_REQ-1:0]    capture;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (hold_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Ready comes straight from the holding flop, so a requester can hand
    // over at most one value every other cycle.
    assign req_echo__RDY = ~hold_valid;
    assign capture       = req_echo__ENA & ~hold_valid;

    assign ind_echo__ENA = out_valid & ind_echo__RDY;
    assign ind_echo_v    = out_data;
    assign ind_echo_src  = out_src;

    // Draining and refilling the output slot in one cycle keeps the
    // downstream busy every cycle when several requesters are pending.
    assign slot_free = !out_valid || ind_echo__ENA;
    assign grant     = slot_free && pick_found;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_data[i] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            // A granted slot is full, so it can never be captured into in
            // the same cycle; the two branches are mutually exclusive.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant && (pick_idx == IDX_W'(i))) begin
                    hold_valid[i] <= 1'b0;
                end else if (capture[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= req_echo_v[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            if (slot_free) begin
                if (pick_found) begin
                    out_valid <= 1'b1;
                    out_data  <= hold_data[pick_idx];
                    out_src   <= pick_idx;
                    rr_ptr    <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef ECHO_ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
        end else if (out_valid && !ind_echo__RDY && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule : echo_indication_arbiter

// File: doc/echo_indication_arbiter.md
# echo_indication_arbiter

Round-robin arbiter that shares one `EchoIndication.echo` method port between `NUM_REQ` independent responder modules, each of which would otherwise call `echo` directly from its `respond` method. Each requester hands off a 32-bit echo value through an `__ENA`/`__RDY` method handshake into a one-entry holding slot. The arbiter moves at most one pending value per cycle into a single output slot, which drives the downstream `echo` method under that method's own `__RDY`/`__ENA` handshake. It sits between the responder array and the indication proxy.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 32: echo payload width.

Ports:
- `CLK`, in, 1: single clock; all state on posedge.
- `nRST`, in, 1: reset, asynchronous, active-low.
- `req_echo__ENA`, in, `NUM_REQ`: per-requester method enable.
- `req_echo_v`, in, `NUM_REQ*DATA_WIDTH`: per-requester payload; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_echo__RDY`, out, `NUM_REQ`: per-requester ready; registered.
- `ind_echo__ENA`, out, 1: downstream `echo` call.
- `ind_echo_v`, out, `DATA_WIDTH`: downstream payload.
- `ind_echo__RDY`, in, 1: downstream ready.
- `ind_echo_src`, out, `$clog2(NUM_REQ)`: index of the requester whose value is in the output slot.
- `stall_count`, out, 32: present only with `ECHO_ARB_STATS_EN`.

## Operation
State:
- `hold_valid[i]` and `hold_data[i]`: one per requester.
- `out_valid`, `out_data`, `out_src`: the output slot.
- `rr_ptr`: round-robin pointer.

Reset (async, `nRST` low):
- All valids 0, `rr_ptr` = 0, `out_data`/`out_src` = 0, `stall_count` = 0.
- `req_echo__RDY` = all ones, `ind_echo__ENA` = 0.

Requester side:
- `req_echo__RDY[i]` = !`hold_valid[i]`.
- Capture occurs when `req_echo__ENA[i]` & `req_echo__RDY[i]`.
- `req_echo__ENA[i]` asserted while RDY is low is a protocol violation. It is ignored, with no capture and no state change.

Downstream:
- `ind_echo__ENA` = `out_valid` & `ind_echo__RDY` (combinational).
- `ind_echo_v` = `out_data`.
- The output slot is free this cycle when `!out_valid` or `ind_echo__ENA`.

Arbitration, evaluated every cycle when the output slot is free:
- Scan `hold_valid` starting at index `rr_ptr`, ascending with wrap modulo `NUM_REQ`. The first set entry wins.
- On a win:
  - Load `out_data`/`out_src` from the winner and set `out_valid`.
  - Clear the winner's `hold_valid`.
  - `rr_ptr` becomes (winner+1) mod `NUM_REQ`.
- No winner and slot drained: `out_valid` clears and `rr_ptr` is unchanged.
- Slot not free: no grant, all holding slots keep their values.

Simultaneous events:
- Capture into slot i and grant of slot i cannot occur in the same cycle, because capture requires `hold_valid[i]` = 0.
- Drain plus refill of the output slot in the same cycle is required, so back-to-back `ind_echo__ENA` is possible.

Ordering:
- Per-requester order is preserved.
- No cross-requester ordering guarantee beyond round-robin.

Reset mid-operation drops all held and in-flight values. Outputs take reset values immediately, with no clock needed.

## Timing
- Capture at edge t. `hold_valid` is set in cycle t+1 and grant occurs in t+1. `out_valid` is set in t+2, and `ind_echo__ENA` is asserted in t+2 if `ind_echo__RDY` is high. Minimum latency is 2 cycles.
- Per-requester throughput is 1 value per 2 cycles, because RDY is registered with no bypass.
- Aggregate throughput is 1 value per cycle when 2 or more requesters are active and downstream is always ready.
- Fairness: a requester with a pending value is granted within `NUM_REQ` output-slot frees.

## Configuration
- `ECHO_ARB_STATS_EN` defined:
  - Adds the `stall_count` port.
  - It increments each cycle that `out_valid` & !`ind_echo__RDY`.
  - It saturates at 0xFFFF_FFFF and resets to 0.
- `ECHO_ARB_STATS_EN` undefined: no `stall_count` port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `echo_arb_pkg`:
  - `DATA_WIDTH` default.
  - `echo_data_t` typedef.
  - `MAX_REQ` = 8 constant.
  - `src_idx_t` typedef.
- One sub-module, `rr_pick`: purely combinational rotate-priority picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: found flag and winner index.
  - It is instantiated once.

## Test plan
- Reset state: drive `nRST` low mid-stream with values in hold and output slots. All `req_echo__RDY` must be 1 and `ind_echo__ENA` 0 asynchronously. After release, a single value 0x12345678 on req 2 must appear at `ind_echo_v` with `ind_echo_src`=2 exactly 2 cycles after capture.
- Round-robin: with `ind_echo__RDY`=1, load all four requesters simultaneously with 0xA0..0xA3. Output order must be 0,1,2,3 on consecutive cycles. Reloading req 0 and req 3 then grants 0 before 3.
- Backpressure: hold `ind_echo__RDY`=0 for 10 cycles with a value in the output slot. `out_data` must stay stable, no grants occur, and with STATS `stall_count`=10. When RDY rises, one `echo` per cycle is issued.
- Single-stream rate: req 1 pushes continuously with downstream always ready. `req_echo__RDY[1]` toggles, giving exactly 1 acceptance per 2 cycles, and data order is preserved for 0..99.
- Protocol violation: pulse `req_echo__ENA[0]` with 0xDEAD while `req_echo__RDY[0]`=0. The held value is unchanged and 0xDEAD never appears on `ind_echo_v`.
- Wrap and saturation (STATS build): preload `stall_count` near max via a long stall. It must stop at 0xFFFFFFFF without wrapping.
